// File: rtl/dmem_pkg.sv
// Shared constants, error codes and helpers for the data-memory responder.
package dmem_pkg;

   localparam int          DMEM_DEPTH_DEF = 1024;
   localparam logic [31:0] DMEM_BASE_DEF  = 32'h0000_0000;

   // Classification of one access; bit 0 = misaligned, bit 1 = out of range.
   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_MISALIGN = 2'd1,
      ERR_RANGE    = 2'd2,
      ERR_BOTH     = 2'd3
   } dmem_err_e;

   // Ceiling log2, usable in parameter and port-width expressions.
   function automatic int clog2(input int unsigned v);
      int          r;
      int unsigned x;
      r = 0;
      x = (v > 0) ? v - 1 : 0;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/dmem_ram_2p.sv
// True dual-port synchronous RAM, read-before-write on both ports.
// Holds storage only: no reset, no error checking, no port arbitration.
module dmem_ram_2p #(
   parameter int W     = 32,
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          CLK,
   input  logic          a_we,
   input  logic          a_re,
   input  logic [AW-1:0] a_addr,
   input  logic [W-1:0]  a_wdata,
   output logic [W-1:0]  a_rdata,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [W-1:0]  b_wdata,
   output logic [W-1:0]  b_rdata
);

   logic [W-1:0] mem [DEPTH];

   // Array writes; a colliding write from both ports is prevented by the caller.
   always_ff @(posedge CLK) begin
      if (a_we) mem[a_addr] <= a_wdata;
      if (b_we) mem[b_addr] <= b_wdata;
   end

   // Registered reads see the contents from before this edge's writes.
   always_ff @(posedge CLK) begin
      if (a_re) a_rdata <= mem[a_addr];
      b_rdata <= mem[b_addr];
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the MEM stage: decodes core accesses, rejects
// misaligned/out-of-range ones, tracks sticky error flags and a saturating
// reject counter, and gives the debug port priority on word collisions.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          size      = 32,
   parameter int          DEPTH     = DMEM_DEPTH_DEF,
   parameter logic [31:0] ADDR_BASE = DMEM_BASE_DEF
) (
   input  logic                    CLK,
   input  logic                    RSTa,
   input  logic [31:0]             address_mem,
   input  logic [size-1:0]         write_data,
   input  logic                    MemWrite_mem,
   input  logic                    MemRead_mem,
   output logic [size-1:0]         read_data_mem,
   output logic                    misalign_err,
   output logic                    range_err,
   output logic [7:0]              err_count,
   input  logic                    dbg_we,
   input  logic [clog2(DEPTH)-1:0] dbg_addr,
   input  logic [size-1:0]         dbg_wdata,
   output logic [size-1:0]         dbg_rdata
);

   localparam int          AW     = clog2(DEPTH);
   localparam logic [63:0] SPAN64 = 64'(DEPTH) << 2;
   localparam logic [63:0] BASE64 = {32'd0, ADDR_BASE};

   // Geometry must be a power-of-two window that fits in the 32-bit space.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dmem_responder: DEPTH must be a power of two >= 2");
   end
   if ((BASE64 % SPAN64) != 64'd0) begin : g_bad_align
      $error("dmem_responder: ADDR_BASE must be aligned to DEPTH*4");
   end
   if ((BASE64 + SPAN64) > 64'h1_0000_0000) begin : g_bad_wrap
      $error("dmem_responder: ADDR_BASE + DEPTH*4 overflows 32 bits");
   end

   logic [32:0]     off33;
   logic            in_range;
   logic            misal;
   logic            access;
   logic            reject;
   logic [AW-1:0]   idx;
   logic            core_we;
   logic            core_re;
   logic            ram_dbg_we;
   logic            rd_zero;
   logic            dbg_zero;
   logic [size-1:0] ram_a_q;
   logic [size-1:0] ram_b_q;

   // Address decode and port gating; reset masks every request.
   always_comb begin
      off33      = {1'b0, address_mem} - {1'b0, ADDR_BASE};
      in_range   = !off33[32] && ((off33 >> (AW + 2)) == 33'd0);
      misal      = address_mem[1:0] != 2'b00;
      access     = MemRead_mem | MemWrite_mem;
      reject     = access & (misal | !in_range);
      idx        = off33[AW+1:2];
      ram_dbg_we = !RSTa && dbg_we;
      core_we    = !RSTa && MemWrite_mem && !reject && !(dbg_we && dbg_addr == idx);
      core_re    = !RSTa && MemRead_mem && !reject;
   end

   dmem_ram_2p #(
      .W     (size),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .CLK     (CLK),
      .a_we    (core_we),
      .a_re    (core_re),
      .a_addr  (idx),
      .a_wdata (write_data),
      .a_rdata (ram_a_q),
      .b_we    (ram_dbg_we),
      .b_addr  (dbg_addr),
      .b_wdata (dbg_wdata),
      .b_rdata (ram_b_q)
   );

   // The RAM has no reset, so zero-forcing flags stand in for cleared read registers.
   always_ff @(posedge CLK) begin
      if (RSTa) begin
         rd_zero      <= 1'b1;
         dbg_zero     <= 1'b1;
         misalign_err <= 1'b0;
         range_err    <= 1'b0;
         err_count    <= 8'd0;
      end else begin
         dbg_zero <= 1'b0;
         if (MemRead_mem) rd_zero <= reject;
         if (reject) begin
            misalign_err <= misalign_err | misal;
            range_err    <= range_err | !in_range;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
         end
      end
   end

   assign read_data_mem = rd_zero  ? '0 : ram_a_q;
   assign dbg_rdata     = dbg_zero ? '0 : ram_b_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a word-array reference model
// checked every cycle, plus hand-computed literal checks per scenario.
module tb_dmem_responder;
   import dmem_pkg::*;

   localparam int          W     = 32;
   localparam int          DEPTH = 1024;
   localparam int          AW    = 10;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   logic          CLK;
   logic          RSTa;
   logic [31:0]   address_mem;
   logic [W-1:0]  write_data;
   logic          MemWrite_mem;
   logic          MemRead_mem;
   logic [W-1:0]  read_data_mem;
   logic          misalign_err;
   logic          range_err;
   logic [7:0]    err_count;
   logic          dbg_we;
   logic [AW-1:0] dbg_addr;
   logic [W-1:0]  dbg_wdata;
   logic [W-1:0]  dbg_rdata;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   dmem_responder #(
      .size      (W),
      .DEPTH     (DEPTH),
      .ADDR_BASE (BASE)
   ) dut (
      .CLK           (CLK),
      .RSTa          (RSTa),
      .address_mem   (address_mem),
      .write_data    (write_data),
      .MemWrite_mem  (MemWrite_mem),
      .MemRead_mem   (MemRead_mem),
      .read_data_mem (read_data_mem),
      .misalign_err  (misalign_err),
      .range_err     (range_err),
      .err_count     (err_count),
      .dbg_we        (dbg_we),
      .dbg_addr      (dbg_addr),
      .dbg_wdata     (dbg_wdata),
      .dbg_rdata     (dbg_rdata)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [31:0] pat(input int i);
      return 32'hC0DE_0000 ^ 32'(i) ^ (32'(i) << 20);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: word array plus flags, updated from the rules per edge.
   logic [31:0] mem_m [DEPTH];
   logic [31:0] exp_rd, exp_dbg;
   logic        exp_mis, exp_rng;
   int          exp_cnt;

   always @(posedge CLK) begin : model
      dmem_err_e       err;
      longint unsigned a;
      int              idx;
      bit              mis, rng;
      if (RSTa) begin
         exp_rd  = '0;
         exp_dbg = '0;
         exp_mis = 1'b0;
         exp_rng = 1'b0;
         exp_cnt = 0;
      end else begin
         exp_dbg = mem_m[dbg_addr];
         a   = longint'(address_mem) & 64'hFFFF_FFFF;
         err = ERR_NONE;
         if (MemRead_mem || MemWrite_mem) begin
            mis = address_mem[1:0] != 2'b00;
            rng = (a < longint'(BASE)) || (a >= longint'(BASE) + longint'(DEPTH) * 4);
            err = dmem_err_e'({rng, mis});
         end
         if (err != ERR_NONE) begin
            if (err == ERR_MISALIGN || err == ERR_BOTH) exp_mis = 1'b1;
            if (err == ERR_RANGE || err == ERR_BOTH) exp_rng = 1'b1;
            if (exp_cnt < 255) exp_cnt = exp_cnt + 1;
            if (MemRead_mem) exp_rd = '0;
         end else if (MemRead_mem || MemWrite_mem) begin
            idx = int'((a - longint'(BASE)) / 4);
            if (MemRead_mem) exp_rd = mem_m[idx];
            if (MemWrite_mem && !(dbg_we && int'(dbg_addr) == idx)) mem_m[idx] = write_data;
         end
         if (dbg_we) mem_m[dbg_addr] = dbg_wdata;
      end
   end

   // Per-cycle compare, half a cycle after each active edge.
   always @(negedge CLK) begin
      if (chk_en) begin
         chk("cyc_rdata", read_data_mem, exp_rd);
         chk("cyc_dbg_rdata", dbg_rdata, exp_dbg);
         chk("cyc_misalign", {31'd0, misalign_err}, {31'd0, exp_mis});
         chk("cyc_range", {31'd0, range_err}, {31'd0, exp_rng});
         chk("cyc_err_count", {24'd0, err_count}, 32'(exp_cnt));
      end
   end

   task automatic cyc(input logic rst, input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wd, input logic dwe, input logic [AW-1:0] da,
                      input logic [31:0] dwd);
      RSTa         = rst;
      MemRead_mem  = rd;
      MemWrite_mem = wr;
      address_mem  = addr;
      write_data   = wd;
      dbg_we       = dwe;
      dbg_addr     = da;
      dbg_wdata    = dwd;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic acc(input logic rd, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
      cyc(1'b0, rd, wr, addr, wd, 1'b0, dbg_addr, 32'd0);
   endtask

   task automatic chk_flags(input string nm, input logic m, input logic r, input logic [7:0] c);
      chk({nm, "_mis"}, {31'd0, misalign_err}, {31'd0, m});
      chk({nm, "_rng"}, {31'd0, range_err}, {31'd0, r});
      chk({nm, "_cnt"}, {24'd0, err_count}, {24'd0, c});
   endtask

   initial begin
      logic [31:0] ra;
      int          r;
      RSTa = 1'b1; MemRead_mem = 1'b0; MemWrite_mem = 1'b0; address_mem = '0;
      write_data = '0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

      // Reset state
      cyc(1'b1, 0, 0, 32'h0, 32'h0, 0, '0, 32'h0);
      cyc(1'b1, 0, 0, 32'h0, 32'h0, 0, '0, 32'h0);
      chk("rst_rdata", read_data_mem, 32'h0);
      chk("rst_dbg_rdata", dbg_rdata, 32'h0);
      chk_flags("rst", 1'b0, 1'b0, 8'd0);

      // Preload every word through the debug port, then one settle cycle
      for (int i = 0; i < DEPTH; i++) cyc(1'b0, 0, 0, 32'h0, 32'h0, 1'b1, AW'(i), pat(i));
      cyc(1'b0, 0, 0, 32'h0, 32'h0, 1'b0, '0, 32'h0);
      chk_en = 1'b1;

      // Store then load at 0x10
      acc(0, 1, 32'h10, 32'hDEAD_BEEF);
      acc(1, 0, 32'h10, 32'h0);
      chk("ld10", read_data_mem, 32'hDEAD_BEEF);
      chk_flags("ld10", 1'b0, 1'b0, 8'd0);
      acc(0, 0, 32'hFFFF_FFFF, 32'h0);
      chk("hold", read_data_mem, 32'hDEAD_BEEF);

      // Same-cycle load and store: read-before-write
      acc(0, 1, 32'h20, 32'h1111_1111);
      acc(1, 1, 32'h20, 32'h2222_2222);
      chk("rbw_old", read_data_mem, 32'h1111_1111);
      acc(1, 0, 32'h20, 32'h0);
      chk("rbw_new", read_data_mem, 32'h2222_2222);

      // Misaligned load, then out-of-range store at the first word past the window
      acc(1, 0, 32'h13, 32'h0);
      chk("mis_rdata", read_data_mem, 32'h0);
      chk_flags("mis", 1'b1, 1'b0, 8'd1);
      acc(0, 1, 32'h1000, 32'h0BAD_0BAD);
      chk_flags("rng", 1'b1, 1'b1, 8'd2);
      acc(1, 0, 32'h0, 32'h0);
      chk("rng_w0", read_data_mem, pat(0));
      acc(1, 0, 32'hFFC, 32'h0);
      chk("rng_wlast", read_data_mem, pat(DEPTH - 1));

      // Both errors in one access count once; then saturation
      cyc(1'b1, 0, 0, 32'h0, 32'h0, 0, '0, 32'h0);
      acc(0, 1, 32'hFFFF_FFFE, 32'h1234_0000);
      chk_flags("both", 1'b1, 1'b1, 8'd1);
      for (int i = 0; i < 300; i++) begin
         if (i % 2 == 0) acc(1, 0, 32'h0000_0101, 32'h0);
         else            acc(0, 1, 32'h0000_2000, 32'hFFFF_0000);
      end
      chk("sat_cnt", {24'd0, err_count}, 32'h0000_00FF);

      // Debug write beats a colliding core store
      cyc(1'b1, 0, 0, 32'h0, 32'h0, 0, '0, 32'h0);
      cyc(1'b0, 0, 1, 32'h14, 32'h0, 1'b1, AW'(5), 32'hA5A5_A5A5);
      cyc(1'b0, 1, 0, 32'h14, 32'h0, 1'b0, AW'(5), 32'h0);
      chk("dbgwin_rdata", read_data_mem, 32'hA5A5_A5A5);
      chk("dbgwin_dbg", dbg_rdata, 32'hA5A5_A5A5);
      chk_flags("dbgwin", 1'b0, 1'b0, 8'd0);

      // Reset mid-stream suppresses a store; array contents survive
      acc(0, 1, 32'h40, 32'h1234_5678);
      acc(1, 1, 32'h44, 32'h0000_0044);
      cyc(1'b1, 0, 1, 32'h40, 32'h0000_0BAD, 0, AW'(16), 32'h0);
      chk("rst2_rdata", read_data_mem, 32'h0);
      chk("rst2_dbg", dbg_rdata, 32'h0);
      chk_flags("rst2", 1'b0, 1'b0, 8'd0);
      acc(1, 0, 32'h40, 32'h0);
      chk("rst2_keep", read_data_mem, 32'h1234_5678);

      // Mixed sweep over a small word window so debug and core collide often
      for (int i = 0; i < 80; i++) begin
         r = $urandom_range(0, 9);
         if (r < 6)      ra = 32'($urandom_range(0, 15)) << 2;
         else if (r < 8) ra = 32'($urandom_range(0, 63));
         else            ra = 32'h0000_1000 + (32'($urandom_range(0, 1000)) << 2);
         cyc(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom,
             1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
      end
      acc(0, 0, 32'h0, 32'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
